// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: Zicsr RMW, ECALL/EBREAK/MRET and trap sequencer for the M-mode CSR file; CSR_ILLEGAL_TRAP_EN adds a privilege/read-only trap.
// Latency: accept->rd_valid 2 cycles, one CSR op per 3 cycles; req_ready is low outside IDLE and while exc_valid is high.
module csr_access_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [1:0]            req_sys,
    input  logic [11:0]           req_csr,
    input  logic [DATA_WIDTH-1:0] req_rs1_val,
    input  logic [4:0]            req_zimm,
    input  logic                  req_rs1_zero,
    input  logic [DATA_WIDTH-1:0] req_pc,
    input  logic                  exc_valid,
    input  logic [DATA_WIDTH-1:0] exc_cause,
    input  logic [DATA_WIDTH-1:0] exc_tval,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    output logic [11:0]           csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_wen,
    output logic [11:0]           csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  exception_commit,
    output logic [DATA_WIDTH-1:0] exception_pc,
    output logic [DATA_WIDTH-1:0] exception_cause,
    output logic [DATA_WIDTH-1:0] exception_tval,
    output logic                  mret_commit,
    output logic                  inst_commit,
    output logic [1:0]            priv_level,
    input  logic [DATA_WIDTH-1:0] handler_addr,
    input  logic [DATA_WIDTH-1:0] mret_out,
    input  logic [DATA_WIDTH-1:0] mstatus_in,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_TRAP  = 3'd3;
    localparam logic [2:0] S_RET   = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [2:0]            state;
    logic [1:0]            op_q;
    logic [11:0]           csr_q;
    logic [DATA_WIDTH-1:0] src_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  rs1_zero_q;
    logic [CNT_W-1:0]      flush_cnt;

    logic                  do_write;
    logic [DATA_WIDTH-1:0] new_val;
    logic                  illegal;
    logic                  accept;
    logic                  trap_go;
    logic [DATA_WIDTH-1:0] trap_cause;
    logic [DATA_WIDTH-1:0] trap_tval;
    logic [DATA_WIDTH-1:0] trap_pc;
    logic                  unused_bits;

    assign unused_bits = ^{mstatus_in[DATA_WIDTH-1:13], mstatus_in[10:0], handler_addr[1:0]};

    assign req_ready = !rst && (state == S_IDLE) && !exc_valid;
    assign accept    = (state == S_IDLE) && req_valid && !exc_valid;
    assign csr_raddr = (state == S_READ) ? csr_q : 12'h000;
    assign flush     = (state == S_FLUSH);

    // RS/RC with an x0/zero source is a pure read and must not touch the CSR.
    always_comb begin
        do_write = (op_q == 2'b01) || !rs1_zero_q;
        new_val  = csr_rdata & ~src_q;
        if (op_q == 2'b01)
            new_val = src_q;
        else if (op_q == 2'b10)
            new_val = csr_rdata | src_q;
    end

`ifdef CSR_ILLEGAL_TRAP_EN
    assign illegal = (priv_level < csr_q[9:8]) || ((csr_q[11:10] == 2'b11) && do_write);
`else
    assign illegal = 1'b0;
`endif

    // Every route into TRAP funnels through here so the commit values are set in one place.
    always_comb begin
        trap_go    = 1'b0;
        trap_cause = '0;
        trap_tval  = '0;
        trap_pc    = pc_q;
        case (state)
            S_IDLE: begin
                if (exc_valid) begin
                    trap_go    = 1'b1;
                    trap_cause = exc_cause;
                    trap_tval  = exc_tval;
                    trap_pc    = exc_pc;
                end else if (req_valid && (req_op[1:0] == 2'b00) && (req_sys == 2'b01)) begin
                    trap_go    = 1'b1;
                    trap_cause = (priv_level == PRIV_M) ? DATA_WIDTH'(11) : DATA_WIDTH'(8);
                    trap_pc    = req_pc;
                end else if (req_valid && (req_op[1:0] == 2'b00) && (req_sys == 2'b10)) begin
                    trap_go    = 1'b1;
                    trap_cause = DATA_WIDTH'(3);
                    trap_tval  = req_pc;
                    trap_pc    = req_pc;
                end
            end
            S_READ: begin
                if (illegal) begin
                    trap_go    = 1'b1;
                    trap_cause = DATA_WIDTH'(2);
                    trap_tval  = DATA_WIDTH'(csr_q);
                end
            end
            S_RET: begin
                if (priv_level != PRIV_M) begin
                    trap_go    = 1'b1;
                    trap_cause = DATA_WIDTH'(2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            op_q             <= '0;
            csr_q            <= '0;
            src_q            <= '0;
            pc_q             <= '0;
            rs1_zero_q       <= 1'b0;
            flush_cnt        <= '0;
            priv_level       <= PRIV_M;
            csr_wen          <= 1'b0;
            csr_waddr        <= '0;
            csr_wdata        <= '0;
            exception_commit <= 1'b0;
            exception_pc     <= '0;
            exception_cause  <= '0;
            exception_tval   <= '0;
            mret_commit      <= 1'b0;
            inst_commit      <= 1'b0;
            rd_valid         <= 1'b0;
            rd_data          <= '0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
        end else begin
            csr_wen          <= 1'b0;
            exception_commit <= 1'b0;
            mret_commit      <= 1'b0;
            inst_commit      <= 1'b0;
            rd_valid         <= 1'b0;
            redirect_valid   <= 1'b0;

            if (accept) begin
                op_q       <= req_op[1:0];
                csr_q      <= req_csr;
                src_q      <= req_op[2] ? DATA_WIDTH'(req_zimm) : req_rs1_val;
                rs1_zero_q <= req_rs1_zero;
                pc_q       <= req_pc;
            end

            if (trap_go) begin
                exception_commit <= 1'b1;
                exception_pc     <= trap_pc;
                exception_cause  <= trap_cause;
                exception_tval   <= trap_tval;
                state            <= S_TRAP;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            if (req_op[1:0] != 2'b00)
                                state <= S_READ;
                            else if (req_sys == 2'b11)
                                state <= S_RET;
                            else
                                inst_commit <= 1'b1;
                        end
                    end
                    S_READ: begin
                        csr_wen     <= do_write;
                        csr_waddr   <= csr_q;
                        csr_wdata   <= new_val;
                        rd_valid    <= 1'b1;
                        rd_data     <= csr_rdata;
                        inst_commit <= 1'b1;
                        state       <= S_WRITE;
                    end
                    S_WRITE: state <= S_IDLE;
                    S_TRAP: begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= {handler_addr[DATA_WIDTH-1:2], 2'b00};
                        priv_level     <= PRIV_M;
                        flush_cnt      <= CNT_W'(FLUSH_CYCLES - 1);
                        state          <= S_FLUSH;
                    end
                    S_RET: begin
                        mret_commit    <= 1'b1;
                        inst_commit    <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= mret_out;
                        priv_level     <= (mstatus_in[12:11] == 2'b11) ? PRIV_M : PRIV_U;
                        flush_cnt      <= CNT_W'(FLUSH_CYCLES - 1);
                        state          <= S_FLUSH;
                    end
                    S_FLUSH: begin
                        if (flush_cnt == '0)
                            state <= S_IDLE;
                        else
                            flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed cases plus randomized ops against a transaction-level model.
// Honours CSR_ILLEGAL_TRAP_EN when the same define is given to the bench.
module tb_csr_access_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        req_valid, req_ready, req_rs1_zero, exc_valid;
    logic [2:0]  req_op;
    logic [1:0]  req_sys, priv_level;
    logic [11:0] req_csr, csr_raddr, csr_waddr;
    logic [4:0]  req_zimm;
    logic [31:0] req_rs1_val, req_pc, exc_cause, exc_tval, exc_pc;
    logic [31:0] csr_rdata, csr_wdata, exception_pc, exception_cause, exception_tval;
    logic [31:0] handler_addr, mret_out, mstatus_in, rd_data, redirect_pc;
    logic        csr_wen, exception_commit, mret_commit, inst_commit, rd_valid;
    logic        redirect_valid, flush;

    int checks = 0;
    int errors = 0;

    logic [31:0] csr_mem [4096];
    logic [31:0] ref_mem [4096];
    logic [1:0]  model_priv = 2'b11;

    always #5 clk = ~clk;

    csr_access_ctrl #(.DATA_WIDTH(32), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sys(req_sys),
        .req_csr(req_csr), .req_rs1_val(req_rs1_val), .req_zimm(req_zimm),
        .req_rs1_zero(req_rs1_zero), .req_pc(req_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wen(csr_wen),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .exception_commit(exception_commit), .exception_pc(exception_pc),
        .exception_cause(exception_cause), .exception_tval(exception_tval),
        .mret_commit(mret_commit), .inst_commit(inst_commit), .priv_level(priv_level),
        .handler_addr(handler_addr), .mret_out(mret_out), .mstatus_in(mstatus_in),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
    );

    // Simple CSR file environment: combinational read, write on csr_wen.
    assign csr_rdata    = csr_mem[csr_raddr];
    assign handler_addr = csr_mem[12'h305];
    assign mret_out     = csr_mem[12'h341];
    assign mstatus_in   = csr_mem[12'h300];

    always @(posedge clk) begin
        if (preload) begin
            csr_mem[12'h300] <= 32'h0000_1888;
            csr_mem[12'h305] <= 32'h0000_0100;
            csr_mem[12'h340] <= 32'h0000_0000;
            csr_mem[12'h341] <= 32'h0000_1000;
            csr_mem[12'h342] <= 32'h0000_0000;
            csr_mem[12'hC00] <= 32'h1234_5678;
            csr_mem[12'h7C0] <= 32'hA5A5_0F0F;
        end else if (csr_wen) begin
            csr_mem[csr_waddr] <= csr_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic start_csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                             input logic [4:0] zimm, input logic rz);
        req_valid    = 1'b1;
        req_op       = op;
        req_sys      = 2'b00;
        req_csr      = a;
        req_rs1_val  = rs1;
        req_zimm     = zimm;
        req_rs1_zero = rz;
        req_pc       = $urandom() & 32'hFFFF_FFFC;
    endtask

    // Remaining FLUSH cycles after the redirect cycle; optionally drives a wrong-path exception.
    task automatic flush_rest(input bit wp);
        if (wp) begin
            exc_valid = 1'b1;
            exc_cause = 32'd5;
            exc_tval  = 32'hDEAD_0000;
            exc_pc    = 32'h0000_0F00;
        end
        for (int i = 1; i < FC; i++) begin
            @(negedge clk);
            chkb("flush_hold", flush, 1'b1);
            chkb("redirect_single", redirect_valid, 1'b0);
            chkb("ready_in_flush", req_ready, 1'b0);
        end
        exc_valid = 1'b0;
        @(negedge clk);
        #1;
        chkb("flush_end", flush, 1'b0);
        chkb("no_wrong_path_trap", exception_commit, 1'b0);
        chkb("ready_after_flush", req_ready, 1'b1);
    endtask

    // Called at the negedge of the TRAP cycle.
    task automatic expect_trap(input logic [31:0] cause, input logic [31:0] tval,
                               input logic [31:0] pc, input bit wp);
        chkb("exc_commit", exception_commit, 1'b1);
        chk("exc_cause", exception_cause, cause);
        chk("exc_tval", exception_tval, tval);
        chk("exc_pc", exception_pc, pc);
        chk("priv_during_trap", {30'b0, priv_level}, {30'b0, model_priv});
        @(negedge clk);
        chkb("exc_commit_pulse", exception_commit, 1'b0);
        chkb("trap_redirect_valid", redirect_valid, 1'b1);
        chk("trap_redirect_pc", redirect_pc, ref_mem[12'h305] & 32'hFFFF_FFFC);
        chkb("trap_flush", flush, 1'b1);
        model_priv = 2'b11;
        chk("priv_after_trap", {30'b0, priv_level}, {30'b0, model_priv});
        flush_rest(wp);
    endtask

    // Completes a CSR op whose request fields are already driven; ends in IDLE.
    task automatic run_csr();
        logic [11:0] a;
        logic [31:0] src, old, nv;
        bit          wen, illegal;
        a   = req_csr;
        src = req_op[2] ? {27'b0, req_zimm} : req_rs1_val;
        old = ref_mem[a];
        case (req_op[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            default: nv = old & ~src;
        endcase
        wen     = (req_op[1:0] == 2'b01) || !req_rs1_zero;
        illegal = 1'b0;
`ifdef CSR_ILLEGAL_TRAP_EN
        illegal = (model_priv < a[9:8]) || ((a[11:10] == 2'b11) && wen);
`endif
        #1;
        chkb("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("csr_raddr", {20'b0, csr_raddr}, {20'b0, a});
        @(negedge clk);
        if (illegal) begin
            chkb("illegal_no_wen", csr_wen, 1'b0);
            chkb("illegal_no_rd", rd_valid, 1'b0);
            chkb("illegal_no_commit", inst_commit, 1'b0);
            expect_trap(32'd2, {20'b0, a}, req_pc, 1'b0);
        end else begin
            chkb("csr_wen", csr_wen, wen);
            if (wen) begin
                chk("csr_waddr", {20'b0, csr_waddr}, {20'b0, a});
                chk("csr_wdata", csr_wdata, nv);
                ref_mem[a] = nv;
            end
            chkb("rd_valid", rd_valid, 1'b1);
            chk("rd_data", rd_data, old);
            chkb("inst_commit", inst_commit, 1'b1);
            @(negedge clk);
            chkb("rd_valid_pulse", rd_valid, 1'b0);
        end
    endtask

    task automatic run_sys(input logic [1:0] sys, input logic [31:0] pc, input bit wp);
        logic [1:0] exp_priv;
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_sys   = sys;
        req_pc    = pc;
        #1;
        chkb("sys_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        case (sys)
            2'b00: chkb("nop_commit", inst_commit, 1'b1);
            2'b01: expect_trap((model_priv == 2'b11) ? 32'd11 : 32'd8, 32'd0, pc, wp);
            2'b10: expect_trap(32'd3, pc, pc, wp);
            default: begin
                @(negedge clk);
                if (model_priv != 2'b11) begin
                    expect_trap(32'd2, 32'd0, pc, wp);
                end else begin
                    exp_priv = (ref_mem[12'h300][12:11] == 2'b11) ? 2'b11 : 2'b00;
                    chkb("mret_commit", mret_commit, 1'b1);
                    chkb("mret_retire", inst_commit, 1'b1);
                    chkb("mret_redirect_valid", redirect_valid, 1'b1);
                    chk("mret_redirect_pc", redirect_pc, ref_mem[12'h341]);
                    chk("mret_priv", {30'b0, priv_level}, {30'b0, exp_priv});
                    chkb("mret_flush", flush, 1'b1);
                    model_priv = exp_priv;
                    flush_rest(wp);
                end
            end
        endcase
    endtask

    initial begin
        logic [11:0] addrs [6] = '{12'h340, 12'h341, 12'h342, 12'h300, 12'h305, 12'hC00};
        logic [2:0]  ops   [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        logic [2:0]  op;
        logic [11:0] a;
        logic        rz;
        int          k;

        ref_mem[12'h300] = 32'h0000_1888;
        ref_mem[12'h305] = 32'h0000_0100;
        ref_mem[12'h340] = 32'h0000_0000;
        ref_mem[12'h341] = 32'h0000_1000;
        ref_mem[12'h342] = 32'h0000_0000;
        ref_mem[12'hC00] = 32'h1234_5678;
        ref_mem[12'h7C0] = 32'hA5A5_0F0F;

        req_valid = 1'b0; req_op = '0; req_sys = '0; req_csr = '0; req_rs1_val = '0;
        req_zimm = '0; req_rs1_zero = 1'b0; req_pc = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_tval = '0; exc_pc = '0;

        repeat (2) @(negedge clk);
        #1;
        chkb("rst_ready", req_ready, 1'b0);
        chk("rst_priv", {30'b0, priv_level}, 32'd3);
        chkb("rst_wen", csr_wen, 1'b0);
        chkb("rst_rd_valid", rd_valid, 1'b0);
        chkb("rst_exc_commit", exception_commit, 1'b0);
        chkb("rst_redirect", redirect_valid, 1'b0);
        chkb("rst_flush", flush, 1'b0);
        chk("rst_raddr", {20'b0, csr_raddr}, 32'd0);
        preload = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        // CSRRW, CSRRS read-only, CSRRCI
        start_csr(3'b001, 12'h340, 32'h0000_1234, 5'd0, 1'b0); run_csr();
        start_csr(3'b010, 12'h300, 32'h0, 5'd0, 1'b1);         run_csr();
        start_csr(3'b111, 12'h300, 32'h0, 5'd8, 1'b0);         run_csr();

        // EBREAK into a misaligned mtvec, with a wrong-path exception during flush
        start_csr(3'b001, 12'h305, 32'h8000_0001, 5'd0, 1'b0); run_csr();
        run_sys(2'b10, 32'h0000_0100, 1'b1);

        // Exception and request in the same cycle: exception wins, request waits
        start_csr(3'b001, 12'h340, 32'h5555_0000, 5'd0, 1'b0);
        exc_valid = 1'b1; exc_cause = 32'd4; exc_tval = 32'h0000_0BAD; exc_pc = 32'h0000_0444;
        #1;
        chkb("exc_blocks_ready", req_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        exc_valid = 1'b0;
        expect_trap(32'd4, 32'h0000_0BAD, 32'h0000_0444, 1'b0);
        run_csr();

        // MRET to U-mode, then accesses and system ops from U-mode
        start_csr(3'b001, 12'h341, 32'h0000_0200, 5'd0, 1'b0); run_csr();
        start_csr(3'b011, 12'h300, 32'h0000_1800, 5'd0, 1'b0); run_csr();
        run_sys(2'b11, 32'h0000_0040, 1'b0);
        start_csr(3'b001, 12'h300, 32'h0000_1888, 5'd0, 1'b0); run_csr();
        run_sys(2'b11, 32'h0000_0080, 1'b0);
        run_sys(2'b01, 32'h0000_00C0, 1'b0);
        run_sys(2'b01, 32'h0000_00C4, 1'b0);
        run_sys(2'b00, 32'h0000_00C8, 1'b0);

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: run_sys(2'b01, $urandom() & 32'hFFFF_FFFC, 1'b0);
                1: run_sys(2'b11, $urandom() & 32'hFFFF_FFFC, 1'b0);
                2: run_sys(2'b10, $urandom() & 32'hFFFF_FFFC, 1'b0);
                3: run_sys(2'b00, $urandom() & 32'hFFFF_FFFC, 1'b0);
                default: begin
                    op = ops[$urandom_range(0, 5)];
                    a  = addrs[$urandom_range(0, 5)];
                    rz = ($urandom_range(0, 3) == 0);
                    start_csr(op, a, rz ? 32'h0 : $urandom(),
                              rz ? 5'd0 : 5'($urandom_range(1, 31)), rz);
                    run_csr();
                end
            endcase
        end

        // Reset in the READ cycle abandons the write
        start_csr(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0, 1'b0);
        #1;
        chkb("midrst_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chkb("midrst_wen", csr_wen, 1'b0);
        chkb("midrst_rd_valid", rd_valid, 1'b0);
        chk("midrst_raddr", {20'b0, csr_raddr}, 32'd0);
        chk("midrst_priv", {30'b0, priv_level}, 32'd3);
        @(negedge clk);
        chkb("midrst_no_commit", inst_commit, 1'b0);
        rst = 1'b0;
        model_priv = 2'b11;
        @(negedge clk);
        start_csr(3'b010, 12'h340, 32'h0, 5'd0, 1'b1); run_csr();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
